// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD MM:SS step helpers for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SET   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_LAP   = 1;
    localparam int unsigned BTN_CLR   = 2;
    localparam int unsigned BTN_DIR   = 3;
    localparam int unsigned BTN_GCLR  = 4;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 99;

    localparam logic [3:0] SEC_TENS_MAX = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_ONES_MAX = 4'(SEC_MAX % 10);
    localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_ONES_MAX = 4'(MIN_MAX % 10);

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } mmss_t;

    // Seconds field +1, wrapping at SEC_MAX, minutes untouched.
    function automatic mmss_t sec_inc(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.s1 == SEC_TENS_MAX && v.s0 == SEC_ONES_MAX) begin
            r.s1 = 4'd0;
            r.s0 = 4'd0;
        end else if (v.s0 == 4'd9) begin
            r.s1 = v.s1 + 4'd1;
            r.s0 = 4'd0;
        end else begin
            r.s0 = v.s0 + 4'd1;
        end
        return r;
    endfunction

    function automatic mmss_t min_inc(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.m1 == MIN_TENS_MAX && v.m0 == MIN_ONES_MAX) begin
            r.m1 = 4'd0;
            r.m0 = 4'd0;
        end else if (v.m0 == 4'd9) begin
            r.m1 = v.m1 + 4'd1;
            r.m0 = 4'd0;
        end else begin
            r.m0 = v.m0 + 4'd1;
        end
        return r;
    endfunction

    function automatic mmss_t sec_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.s1 == 4'd0 && v.s0 == 4'd0) begin
            r.s1 = SEC_TENS_MAX;
            r.s0 = SEC_ONES_MAX;
        end else if (v.s0 == 4'd0) begin
            r.s1 = v.s1 - 4'd1;
            r.s0 = 4'd9;
        end else begin
            r.s0 = v.s0 - 4'd1;
        end
        return r;
    endfunction

    function automatic mmss_t min_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.m1 == 4'd0 && v.m0 == 4'd0) begin
            r.m1 = MIN_TENS_MAX;
            r.m0 = MIN_ONES_MAX;
        end else if (v.m0 == 4'd0) begin
            r.m1 = v.m1 - 4'd1;
            r.m0 = 4'd9;
        end else begin
            r.m0 = v.m0 - 4'd1;
        end
        return r;
    endfunction

    // Full-timer steps: seconds carry/borrow into minutes, whole range wraps.
    function automatic mmss_t mmss_up(input mmss_t v);
        mmss_t r;
        r = sec_inc(v);
        if (v.s1 == SEC_TENS_MAX && v.s0 == SEC_ONES_MAX) r = min_inc(r);
        return r;
    endfunction

    function automatic mmss_t mmss_down(input mmss_t v);
        mmss_t r;
        r = sec_dec(v);
        if (v.s1 == 4'd0 && v.s0 == 4'd0) r = min_dec(r);
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mmss_counter.sv
// MM:SS BCD register with tick up/down and manual minute/second presets.
module bcd_mmss_counter
    import stopwatch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  inc,
    input  logic  dec,
    input  logic  add_min,
    input  logic  add_sec,
    output mmss_t value,
    output logic  is_zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= mmss_up(value);
        end else if (dec) begin
            value <= mmss_down(value);
        end else if (add_min) begin
            value <= min_inc(value);
        end else if (add_sec) begin
            value <= sec_inc(value);
        end
    end

    assign is_zero = (value == '0);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button FSM, 1 s prescaler, lap freeze and display select.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  pressed,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap,
    output logic        dir_down,
    output logic        done,
    output logic [1:0]  state
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] presc;
    mmss_t            count, frozen, tick_next;
    logic             cnt_zero, counting, tick, reach_zero;
    logic             cnt_clear, cnt_inc, cnt_dec, add_min, add_sec;
    logic             dir_toggle, dir_clear, presc_clear, lap_capture, done_nxt;

    bcd_mmss_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .dec     (cnt_dec),
        .add_min (add_min),
        .add_sec (add_sec),
        .value   (count),
        .is_zero (cnt_zero)
    );

    assign counting   = (state_q == RUN) || (state_q == LAP);
    assign tick       = counting && (presc == TICK_LAST);
    assign tick_next  = dir_down ? mmss_down(count) : mmss_up(count);
    assign reach_zero = tick && dir_down && (tick_next == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SET;
        else      state_q <= state_nxt;
    end

    // Only the highest-priority pulse acts; a down count hitting zero wins the transition.
    always_comb begin
        state_nxt   = state_q;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        cnt_dec     = 1'b0;
        add_min     = 1'b0;
        add_sec     = 1'b0;
        dir_toggle  = 1'b0;
        dir_clear   = 1'b0;
        presc_clear = 1'b0;
        lap_capture = 1'b0;
        done_nxt    = 1'b0;
        if (pressed[BTN_GCLR]) begin
            state_nxt   = SET;
            cnt_clear   = 1'b1;
            presc_clear = 1'b1;
            dir_clear   = 1'b1;
        end else begin
            cnt_inc = tick && !dir_down;
            cnt_dec = tick && dir_down;
            case (state_q)
                SET: begin
                    if (pressed[BTN_START]) begin
                        if (!(dir_down && cnt_zero)) begin
                            state_nxt   = RUN;
                            presc_clear = 1'b1;
                        end
                    end else if (pressed[BTN_LAP]) begin
                        add_min = 1'b1;
                    end else if (pressed[BTN_CLR]) begin
                        add_sec = 1'b1;
                    end else if (pressed[BTN_DIR]) begin
                        dir_toggle = 1'b1;
                    end
                end
                RUN: begin
                    if (pressed[BTN_START]) begin
                        state_nxt = PAUSE;
                    end else if (pressed[BTN_LAP]) begin
                        state_nxt   = LAP;
                        lap_capture = 1'b1;
                    end
                end
                LAP: begin
                    if (pressed[BTN_START])    state_nxt = PAUSE;
                    else if (pressed[BTN_LAP]) state_nxt = RUN;
                end
                PAUSE: begin
                    if (pressed[BTN_START]) begin
                        state_nxt = RUN;
                    end else if (pressed[BTN_LAP]) begin
                        state_nxt = PAUSE;
                    end else if (pressed[BTN_CLR]) begin
                        state_nxt = SET;
                        cnt_clear = 1'b1;
                    end else if (pressed[BTN_DIR]) begin
                        dir_toggle = 1'b1;
                    end
                end
                default: state_nxt = SET;
            endcase
            if (reach_zero) begin
                state_nxt   = SET;
                presc_clear = 1'b1;
                done_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            dir_down <= 1'b0;
            done     <= 1'b0;
            frozen   <= '0;
        end else begin
            done <= done_nxt;
            if (presc_clear || tick) presc <= '0;
            else if (counting)       presc <= presc + CNT_W'(1);
            if (dir_clear)       dir_down <= 1'b0;
            else if (dir_toggle) dir_down <= ~dir_down;
            // Lap captures the value the counter will hold after this edge.
            if (lap_capture) frozen <= tick ? tick_next : count;
        end
    end

    assign state   = state_q;
    assign running = counting;
    assign lap     = (state_q == LAP);
    assign disp    = (state_q == LAP) ? frozen : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a 4-cycle tick.
module tb_stopwatch_ctrl;

    typedef logic [21:0] obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  pressed = 5'd0;
    logic [15:0] disp;
    logic        running, lap, dir_down, done;
    logic [1:0]  state;
    obs_t        obs;

    int n_tests = 0;
    int n_fail  = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    stopwatch_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .pressed  (pressed),
        .disp     (disp),
        .running  (running),
        .lap      (lap),
        .dir_down (dir_down),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    assign obs = {disp, running, lap, dir_down, done, state};

    function automatic obs_t mk(input logic [15:0] d, input logic r, input logic l,
                                input logic dd, input logic dn, input logic [1:0] s);
        return {d, r, l, dd, dn, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_obs(input string tag, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_compare();
        obs_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(obs), 32'(e));
        end
    endtask

    task automatic pulse(input logic [4:0] b);
        pressed = b;
        @(posedge clk);
        #1 pressed = 5'd0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        expect_obs("reset", mk(16'h0000, 0, 0, 0, 0, 2'd0));
        sb_compare();
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic run and pause
        expect_obs("t1_run4", mk(16'h0004, 1, 0, 0, 0, 2'd1));
        pulse(5'b00001);
        cycles(16);
        sb_compare();
        expect_obs("t1_pause", mk(16'h0004, 0, 0, 0, 0, 2'd2));
        pulse(5'b00001);
        sb_compare();
        expect_obs("t1_hold", mk(16'h0004, 0, 0, 0, 0, 2'd2));
        cycles(8);
        sb_compare();

        // Seconds carry into minutes
        expect_obs("t2_gclr", mk(16'h0000, 0, 0, 0, 0, 2'd0));
        pulse(5'b10000);
        sb_compare();
        expect_obs("t2_preload", mk(16'h0058, 0, 0, 0, 0, 2'd0));
        repeat (58) pulse(5'b00100);
        sb_compare();
        expect_obs("t2_59", mk(16'h0059, 1, 0, 0, 0, 2'd1));
        pulse(5'b00001);
        cycles(4);
        sb_compare();
        expect_obs("t2_100", mk(16'h0100, 1, 0, 0, 0, 2'd1));
        cycles(4);
        sb_compare();

        // Lap freeze
        pulse(5'b10000);
        expect_obs("t3_run3", mk(16'h0003, 1, 0, 0, 0, 2'd1));
        pulse(5'b00001);
        cycles(12);
        sb_compare();
        expect_obs("t3_lap", mk(16'h0003, 1, 1, 0, 0, 2'd3));
        pulse(5'b00010);
        sb_compare();
        expect_obs("t3_frozen", mk(16'h0003, 1, 1, 0, 0, 2'd3));
        cycles(12);
        sb_compare();
        expect_obs("t3_live", mk(16'h0006, 1, 0, 0, 0, 2'd1));
        pulse(5'b00010);
        sb_compare();

        // Down count to zero
        pulse(5'b10000);
        expect_obs("t4_dir", mk(16'h0000, 0, 0, 1, 0, 2'd0));
        pulse(5'b01000);
        sb_compare();
        expect_obs("t4_preload", mk(16'h0002, 0, 0, 1, 0, 2'd0));
        repeat (2) pulse(5'b00100);
        sb_compare();
        expect_obs("t4_01", mk(16'h0001, 1, 0, 1, 0, 2'd1));
        pulse(5'b00001);
        cycles(4);
        sb_compare();
        expect_obs("t4_pre_zero", mk(16'h0001, 1, 0, 1, 0, 2'd1));
        cycles(3);
        sb_compare();
        expect_obs("t4_done", mk(16'h0000, 0, 0, 1, 1, 2'd0));
        cycles(1);
        sb_compare();
        expect_obs("t4_done_drop", mk(16'h0000, 0, 0, 1, 0, 2'd0));
        cycles(1);
        sb_compare();
        expect_obs("t4_start_ignored", mk(16'h0000, 0, 0, 1, 0, 2'd0));
        pulse(5'b00001);
        cycles(2);
        sb_compare();

        // Global clear beats start, then async reset mid-run
        pulse(5'b10000);
        repeat (12) pulse(5'b00010);
        repeat (34) pulse(5'b00100);
        expect_obs("t5_set1234", mk(16'h1234, 0, 0, 0, 0, 2'd0));
        sb_compare();
        expect_obs("t5_pause", mk(16'h1234, 0, 0, 0, 0, 2'd2));
        pulse(5'b00001);
        pulse(5'b00001);
        sb_compare();
        expect_obs("t5_dir", mk(16'h1234, 0, 0, 1, 0, 2'd2));
        pulse(5'b01000);
        sb_compare();
        expect_obs("t5_gclr_prio", mk(16'h0000, 0, 0, 0, 0, 2'd0));
        pulse(5'b10001);
        sb_compare();
        expect_obs("t5_run1", mk(16'h0001, 1, 0, 0, 0, 2'd1));
        pulse(5'b00001);
        cycles(6);
        sb_compare();
        expect_obs("t5_async_rst", mk(16'h0000, 0, 0, 0, 0, 2'd0));
        #2 rst = 1'b0;
        #1 sb_compare();
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Full wrap 99:59 -> 00:00 keeps running
        expect_obs("t6_preload", mk(16'h9959, 0, 0, 0, 0, 2'd0));
        repeat (99) pulse(5'b00010);
        repeat (59) pulse(5'b00100);
        sb_compare();
        expect_obs("t6_wrap", mk(16'h0000, 1, 0, 0, 0, 2'd1));
        pulse(5'b00001);
        cycles(4);
        sb_compare();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Consumes the one-cycle, debounced button pulses produced by the push-button conditioning stage (pressed[4:0]).
- Runs a 4-state control FSM and an MM:SS BCD timer that can count up or down.
- Drives a 16-bit BCD display word and status flags to the downstream 7-segment scan driver.
- Sits between the button conditioning stage and the display driver.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s timer tick (must be >= 2)
CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
pressed  input  5  one-cycle pulses: [0] start/pause, [1] lap or +1 min, [2] clear or +1 s, [3] direction toggle, [4] global clear
disp  output  16  BCD {M1,M0,S1,S0}; live count, or frozen count while in LAP
running  output  1  high in RUN or LAP
lap  output  1  high in LAP
dir_down  output  1  1 = count down
done  output  1  one-cycle pulse when a down count reaches 00:00
state  output  2  SET=0, RUN=1, PAUSE=2, LAP=3

Behaviour:
- Reset (rst=0, async): state=SET, count=00:00, frozen=00:00, prescaler=0, dir_down=0, done=0, disp=16'h0000.
- Latency: pulse in cycle n updates registers at the closing edge of cycle n; the effect is visible in cycle n+1.
- Simultaneous pulses: only the highest-priority pulse is acted on. Priority is [4] > [0] > [1] > [2] > [3].
- pressed[4], any state: go to SET; count=00:00; prescaler=0; dir_down=0. Overrides a tick in the same cycle.
- SET state:
  - [0]: go to RUN with prescaler=0. Ignored if dir_down=1 and count=00:00.
  - [1]: minutes +1 in BCD, 99 wraps to 00; seconds unchanged.
  - [2]: seconds +1 in BCD, 59 wraps to 00; no carry into minutes.
  - [3]: toggle dir_down.
- RUN state:
  - [0]: go to PAUSE.
  - [1]: go to LAP; frozen <= count value after this cycle's tick, if any.
  - [2], [3]: ignored.
- LAP state:
  - [1]: go to RUN (display live again).
  - [0]: go to PAUSE (display live again).
  - [2], [3]: ignored.
- PAUSE state:
  - [0]: go to RUN; prescaler resumes from its held value.
  - [2]: go to SET; count=00:00.
  - [3]: toggle dir_down.
  - [1]: ignored.
- Prescaler:
  - Increments only in RUN or LAP; held in SET and PAUSE.
  - tick = (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
- Tick, up direction:
  - Seconds 59 -> 00 with carry into minutes.
  - 99:59 -> 00:00; the timer keeps running (wrap).
- Tick, down direction:
  - Seconds 00 -> 59 with borrow from minutes.
  - Tick that produces 00:00: done=1 for exactly that next cycle, state goes to SET, prescaler=0.
- Tick in the same cycle as a state-changing pulse: the count update is still applied, judged on the pre-edge state (RUN/LAP), and the transition is taken.
- disp = frozen when state is LAP, otherwise count. All outputs are registered or decoded from registers only; no combinational path from pressed to any output.
- BCD digits never leave their legal ranges: S1 0-5, S0/M1/M0 0-9.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encodings SET/RUN/PAUSE/LAP;
  - button index constants BTN_START=0, BTN_LAP=1, BTN_CLR=2, BTN_DIR=3, BTN_GCLR=4;
  - BCD limit constants SEC_MAX=59, MIN_MAX=99.
- One sub-module, bcd_mmss_counter. It holds the MM:SS register with inputs inc, dec, add_min, add_sec, clear and outputs value and is_zero.
- The FSM, prescaler and lap register stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4):
- Release rst, pulse [0], wait 4 ticks -> disp=16'h0004, running=1, state=1; pulse [0] -> state=2; 8 more cycles -> disp stays 16'h0004.
- Preload 00:58 via [2] x58 in SET, run up for 2 ticks -> disp 16'h0059 then 16'h0100.
- In RUN at 00:03 pulse [1], wait 3 ticks -> disp stays 16'h0003, lap=1; pulse [1] -> disp=16'h0006 live.
- SET, toggle [3], [2] x2, [0]; after 2 ticks -> disp=16'h0000, done high exactly 1 cycle, state=0; a later [0] is ignored.
- [0] and [4] in the same cycle while in PAUSE at 12:34 -> state=0, disp=16'h0000, dir_down=0; drop rst mid-RUN -> all outputs zero immediately, before the next clk edge.
- Preload 99:59 up, run 1 tick -> disp=16'h0000, running=1, done=0.
